// File: rtl/adaboost_seq_ctrl.sv
// adaboost_seq_ctrl: sequences the three-classifier AdaBoost bagging datapath
// through weight load, feature stream and result wait for one inference.
// Optional macro ADABOOST_SEQ_TIMEOUT_EN bounds the result wait and flags err.
module adaboost_seq_ctrl #(
  parameter int unsigned N_FEAT         = 30,
  parameter int unsigned WW             = 9,
  parameter int unsigned AW             = 5,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_weights,
  input  logic [N_FEAT-1:0] feat_vec,
  output logic [1:0]        wmem_sel,
  output logic [AW-1:0]     wmem_addr,
  input  logic [WW-1:0]     wmem_rdata,
  output logic [2:0]        write,
  output logic [WW-1:0]     weight,
  output logic              read,
  output logic              en,
  output logic [AW-1:0]     address,
  output logic [1:0]        data,
  input  logic              total_ready,
  input  logic [1:0]        total_predict,
  output logic              busy,
  output logic              done,
  output logic [1:0]        result,
  output logic              err
);

  localparam int unsigned NB        = 3;
  localparam logic [1:0]  LAST_BANK = 2'(NB - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_FEAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_WAIT, S_DONE} state_t;

  state_t              state, state_n;
  logic [N_FEAT-1:0]   feat, feat_n;
  logic                weights_valid, weights_valid_n;
  logic                rd_act, rd_act_n;
  logic [1:0]          wmem_sel_n;
  logic [AW-1:0]       wmem_addr_n;
  logic [2:0]          write_n;
  logic [AW-1:0]       address_n;
  logic [AW-1:0]       nxt_idx;
  logic                read_n, en_n, busy_n, done_n, err_n;
  logic [1:0]          data_n, result_n;
`ifdef ADABOOST_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]       wait_cnt, wait_cnt_n;
`endif

  // ROM data arrives one cycle after its address, aligned with the write strobe
  assign weight = (write != 3'b000) ? wmem_rdata : '0;

  // Next-state and next-output decode
  always_comb begin
    state_n         = state;
    feat_n          = feat;
    weights_valid_n = weights_valid;
    rd_act_n        = 1'b0;
    wmem_sel_n      = 2'b00;
    wmem_addr_n     = '0;
    write_n         = 3'b000;
    address_n       = '0;
    nxt_idx         = '0;
    read_n          = 1'b0;
    en_n            = 1'b0;
    data_n          = 2'b00;
    busy_n          = busy;
    done_n          = 1'b0;
    result_n        = result;
    err_n           = err;
`ifdef ADABOOST_SEQ_TIMEOUT_EN
    wait_cnt_n      = '0;
`endif
    // A read issued this cycle becomes a write to the same bank/address next cycle
    if (rd_act) begin
      write_n   = 3'(1) << wmem_sel;
      address_n = wmem_addr;
    end
    case (state)
      S_IDLE: begin
        if (start) begin
          feat_n   = feat_vec;
          err_n    = 1'b0;
          result_n = 2'b00;
          busy_n   = 1'b1;
          if (load_weights || !weights_valid) begin
            state_n  = S_LOAD;
            rd_act_n = 1'b1;
          end else begin
            state_n = S_STREAM;
            en_n    = 1'b1;
            read_n  = 1'b1;
            data_n  = {1'b0, feat_vec[0]};
          end
        end
      end
      S_LOAD: begin
        if (rd_act) begin
          if (!(wmem_sel == LAST_BANK && wmem_addr == LAST_IDX)) begin
            rd_act_n = 1'b1;
            if (wmem_addr == LAST_IDX) begin
              wmem_sel_n  = wmem_sel + 2'd1;
              wmem_addr_n = '0;
            end else begin
              wmem_sel_n  = wmem_sel;
              wmem_addr_n = wmem_addr + AW'(1);
            end
          end
        end else begin
          // Last write is on the bus this cycle; stream starts next
          weights_valid_n = 1'b1;
          state_n         = S_STREAM;
          en_n            = 1'b1;
          read_n          = 1'b1;
          data_n          = {1'b0, feat[0]};
        end
      end
      S_STREAM: begin
        if (address == LAST_IDX) begin
          state_n = S_WAIT;
        end else begin
          nxt_idx   = address + AW'(1);
          en_n      = 1'b1;
          read_n    = 1'b1;
          address_n = nxt_idx;
          data_n    = {1'b0, feat[nxt_idx]};
        end
      end
      S_WAIT: begin
`ifdef ADABOOST_SEQ_TIMEOUT_EN
        wait_cnt_n = wait_cnt + TW'(1);
`endif
        if (total_ready) begin
          result_n = total_predict;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = S_DONE;
        end
`ifdef ADABOOST_SEQ_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err_n    = 1'b1;
          result_n = 2'b00;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = S_DONE;
        end
`endif
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      feat          <= '0;
      weights_valid <= 1'b0;
      rd_act        <= 1'b0;
      wmem_sel      <= 2'b00;
      wmem_addr     <= '0;
      write         <= 3'b000;
      address       <= '0;
      read          <= 1'b0;
      en            <= 1'b0;
      data          <= 2'b00;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= 2'b00;
      err           <= 1'b0;
`ifdef ADABOOST_SEQ_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      state         <= state_n;
      feat          <= feat_n;
      weights_valid <= weights_valid_n;
      rd_act        <= rd_act_n;
      wmem_sel      <= wmem_sel_n;
      wmem_addr     <= wmem_addr_n;
      write         <= write_n;
      address       <= address_n;
      read          <= read_n;
      en            <= en_n;
      data          <= data_n;
      busy          <= busy_n;
      done          <= done_n;
      result        <= result_n;
      err           <= err_n;
`ifdef ADABOOST_SEQ_TIMEOUT_EN
      wait_cnt      <= wait_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_adaboost_seq_ctrl.sv
// Bench for adaboost_seq_ctrl: timeline model of one inference compared
// against every DUT output each cycle, plus literal spot checks.
module tb_adaboost_seq_ctrl;

  localparam int unsigned N_FEAT = 30;
  localparam int unsigned WW     = 9;
  localparam int unsigned AW     = 5;
  localparam int          TO     = 256;
  localparam logic [29:0] FEAT0  = 30'b001000000001001001111111010110;

  logic              clk = 1'b0;
  logic              rst, start, load_weights;
  logic [N_FEAT-1:0] feat_vec;
  logic [1:0]        wmem_sel;
  logic [AW-1:0]     wmem_addr;
  logic [WW-1:0]     wmem_rdata;
  logic [2:0]        write;
  logic [WW-1:0]     weight;
  logic              read, en;
  logic [AW-1:0]     address;
  logic [1:0]        data;
  logic              total_ready;
  logic [1:0]        total_predict;
  logic              busy, done;
  logic [1:0]        result;
  logic              err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adaboost_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .load_weights(load_weights),
    .feat_vec(feat_vec), .wmem_sel(wmem_sel), .wmem_addr(wmem_addr),
    .wmem_rdata(wmem_rdata), .write(write), .weight(weight), .read(read),
    .en(en), .address(address), .data(data), .total_ready(total_ready),
    .total_predict(total_predict), .busy(busy), .done(done),
    .result(result), .err(err)
  );

  function automatic logic [WW-1:0] rom_word(int b, int a);
    return WW'(b * 128 + a);
  endfunction

  // Weight ROM: one-cycle read latency
  always @(posedge clk) wmem_rdata <= rom_word(int'(wmem_sel), int'(wmem_addr));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Model: ph 0 idle, 1 active, 2 done cycle; e = edge that accepted start
  int          cur = 0, e = 0, ph = 0, mk, mwb;
  bit          m_ld, m_wv, m_err, chk_en = 1'b0;
  logic [1:0]  m_res;
  logic [29:0] m_feat;

  always @(posedge clk) begin
    cur++;
    if (rst) begin
      ph = 0; m_wv = 1'b0; m_res = 2'b00; m_err = 1'b0; chk_en = 1'b1;
    end else if (ph == 2) begin
      ph = 0;
    end else if (ph == 0) begin
      if (start) begin
        e = cur; m_ld = load_weights || !m_wv; ph = 1;
        m_err = 1'b0; m_res = 2'b00; m_feat = feat_vec;
      end
    end else begin
      mk  = cur - e + 1;
      mwb = m_ld ? 122 : 31;
      if (m_ld && mk == 92) m_wv = 1'b1;
      if (mk - 1 >= mwb) begin
        if (total_ready) begin
          ph = 2; m_res = total_predict;
        end
`ifdef ADABOOST_SEQ_TIMEOUT_EN
        else if (mk - 1 - mwb == TO - 1) begin
          ph = 2; m_err = 1'b1; m_res = 2'b00;
        end
`endif
      end
    end
  end

  // Compare every output against the model each cycle
  always @(negedge clk) begin
    int k, j, s;
    logic [1:0] x_sel, x_data;
    logic [AW-1:0] x_waddr, x_addr;
    logic [2:0] x_write;
    logic [WW-1:0] x_weight;
    logic x_en;
    if (chk_en) begin
      x_sel = 2'b00; x_waddr = '0; x_write = 3'b000; x_addr = '0;
      x_weight = '0; x_en = 1'b0; x_data = 2'b00;
      if (ph == 1) begin
        k = cur - e + 1;
        if (m_ld && k >= 1 && k <= 90) begin
          x_sel = 2'((k - 1) / 30); x_waddr = AW'((k - 1) % 30);
        end
        if (m_ld && k >= 2 && k <= 91) begin
          j = k - 2;
          x_write = 3'(1 << (j / 30)); x_addr = AW'(j % 30);
          x_weight = rom_word(j / 30, j % 30);
        end
        s = k - (m_ld ? 92 : 1);
        if (s >= 0 && s < 30) begin
          x_en = 1'b1; x_addr = AW'(s); x_data = {1'b0, m_feat[s]};
        end
      end
      chk("wmem_sel", 32'(wmem_sel), 32'(x_sel));
      chk("wmem_addr", 32'(wmem_addr), 32'(x_waddr));
      chk("write", 32'(write), 32'(x_write));
      chk("weight", 32'(weight), 32'(x_weight));
      chk("address", 32'(address), 32'(x_addr));
      chk("en", 32'(en), 32'(x_en));
      chk("read", 32'(read), 32'(x_en));
      chk("data", 32'(data), 32'(x_data));
      chk("busy", 32'(busy), 32'(ph == 1));
      chk("done", 32'(done), 32'(ph == 2));
      chk("result", 32'(result), 32'(m_res));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(bit ld, logic [29:0] f);
    start = 1'b1; load_weights = ld; feat_vec = f;
    tick(1);
    start = 1'b0; load_weights = 1'($urandom); feat_vec = 30'($urandom);
  endtask

  // Run from cycle cc to the result; ready arrives d cycles into WAIT
  task automatic finish_txn(bit ld, int cc, int d, logic [1:0] tp, bit noise);
    int wb, tgt;
    wb  = ld ? 122 : 31;
    tgt = (cc > wb + d) ? cc : wb + d;
    for (int c = cc; c <= tgt; c++) begin
      start = noise && ($urandom_range(0, 7) == 0);
      if (c == tgt) begin
        total_ready = 1'b1; total_predict = tp;
      end else begin
        total_ready = noise && (c < wb) && ($urandom_range(0, 5) == 0);
        total_predict = 2'($urandom);
      end
      tick(1);
    end
    total_ready = 1'b0;
    start = noise && ($urandom_range(0, 1) == 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("result_on_done", 32'(result), 32'(tp));
    chk("busy_on_done", 32'(busy), 32'd0);
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    bit ld;
    rst = 1'b1; start = 1'b0; load_weights = 1'b0; feat_vec = '0;
    total_ready = 1'b0; total_predict = 2'b00;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    tick(1);

    // Full load then stream with the reference feature vector
    do_start(1'b1, FEAT0);
    @(negedge clk);
    chk("rd_first_sel", 32'(wmem_sel), 32'd0);
    tick(1);
    chk("wr_first", 32'(write), 32'h1);
    chk("wr_first_wt", 32'(weight), 32'h0);
    tick(89);
    chk("wr_last", 32'(write), 32'h4);
    chk("wr_last_addr", 32'(address), 32'd29);
    chk("wr_last_wt", 32'(weight), 32'h11D);
    tick(1);
    chk("stream0_data", 32'(data), 32'd0);
    chk("stream0_en", 32'(en), 32'd1);
    tick(1);
    chk("stream1_data", 32'(data), 32'd1);
    finish_txn(1'b1, 93, 4, 2'b01, 1'b0);

    // Reuse weights; -1 result
    do_start(1'b0, FEAT0);
    @(negedge clk);
    chk("noload_en_c1", 32'(en), 32'd1);
    chk("noload_write_c1", 32'(write), 32'd0);
    finish_txn(1'b0, 1, 3, 2'b11, 1'b1);
    chk("result_hold", 32'(result), 32'h3);

    // total_ready while idle must not produce done
    total_ready = 1'b1; total_predict = 2'b01;
    tick(2);
    chk("idle_ready_done", 32'(done), 32'd0);
    total_ready = 1'b0;

    // Reset mid-load, then a no-load request still forces a full load
    do_start(1'b1, 30'($urandom));
    tick(44);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(1);
    do_start(1'b0, 30'($urandom));
    tick(1);
    chk("forced_load_write", 32'(write), 32'h1);
    finish_txn(1'b1, 2, 0, 2'b01, 1'b1);

    // Randomized transactions
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        rst = 1'b1; tick(1); rst = 1'b0; tick(1);
      end
      ld = ($urandom_range(0, 2) == 0) || !m_wv;
      do_start(ld, 30'($urandom));
      finish_txn(ld, 1, int'($urandom_range(0, 20)),
                 ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11, 1'b1);
    end

    // No total_ready at all
    ld = !m_wv;
    do_start(1'b0, 30'($urandom));
`ifdef ADABOOST_SEQ_TIMEOUT_EN
    tick((ld ? 122 : 31) + 255 - 1);
    chk("pre_timeout_busy", 32'(busy), 32'd1);
    tick(1);
    chk("timeout_done", 32'(done), 32'd1);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_result", 32'(result), 32'd0);
    tick(2);
`else
    tick(1000);
    chk("no_timeout_busy", 32'(busy), 32'd1);
    chk("no_timeout_err", 32'(err), 32'd0);
    finish_txn(ld, 1001, 0, 2'b01, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
